// File: rtl/sobel_stream_param.sv
// Streaming 3x3 Sobel filter: |Gx|, |Gy|, |Gx|+|Gy| or centre-pixel bypass.
// One pixel accepted per enabled clock; each result appears 3 clocks after its accept.
module sobel_stream_param #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             frame_start,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] pixel_in,
  output logic             out_valid,
  output logic [PIX_W-1:0] pixel_out,
  output logic             frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int GW = PIX_W + 4;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [GW-1:0] SAT_MAX  = GW'((1 << PIX_W) - 1);

  localparam logic [1:0] MODE_GX     = 2'd0;
  localparam logic [1:0] MODE_GY     = 2'd1;
  localparam logic [1:0] MODE_BYPASS = 2'd3;

  // Position / mode state
  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;
  logic [1:0]    mode_q, cur_mode;
  logic          at_origin;

  // Line buffers and window; win[0] is the oldest row, win[x][0] the leftmost column
  logic [PIX_W-1:0] lb0 [IMG_WIDTH];
  logic [PIX_W-1:0] lb1 [IMG_WIDTH];
  logic [PIX_W-1:0] win [3][3];

  // Pipeline registers
  logic                 s1_valid, s1_border, s1_last;
  logic [1:0]           s1_mode;
  logic                 s2_valid, s2_border, s2_last;
  logic [1:0]           s2_mode;
  logic [PIX_W-1:0]     s2_centre;
  logic signed [GW-1:0] s2_gx, s2_gy;
  logic                 s3_valid, s3_border, s3_last;
  logic [1:0]           s3_mode;
  logic [PIX_W-1:0]     s3_centre;
  logic [GW-1:0]        s3_ax, s3_ay;

  logic signed [GW-1:0] gx_c, gy_c;
  logic [GW-1:0]        ax_c, ay_c, mag_c;
  logic [PIX_W-1:0]     result_c;

  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({4'b0000, p});
  endfunction

  // Position of the pixel being offered; frame_start overrides the running counters
  always_comb begin
    cur_col   = frame_start ? '0 : col;
    cur_row   = frame_start ? '0 : row;
    at_origin = (cur_col == '0) && (cur_row == '0);
    cur_mode  = at_origin ? mode : mode_q;
  end

  // Raster counters and mode latch advance on every accepted pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col    <= '0;
      row    <= '0;
      mode_q <= '0;
    end else if (en) begin
      mode_q <= cur_mode;
      if (cur_col == COL_LAST) begin
        col <= '0;
        row <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
      end else begin
        col <= cur_col + CW'(1);
        row <= cur_row;
      end
    end
  end

  // Line buffer update; contents are never reset since border masking hides them
  always_ff @(posedge clk) begin
    if (en) begin
      lb1[cur_col] <= lb0[cur_col];
      lb0[cur_col] <= pixel_in;
    end
  end

  // Stage 1: window shift plus border/last/mode tags for the accepted pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win[i][j] <= '0;
        end
      end
      s1_valid  <= 1'b0;
      s1_border <= 1'b0;
      s1_last   <= 1'b0;
      s1_mode   <= '0;
    end else begin
      s1_valid <= en;
      if (en) begin
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= lb1[cur_col];
        win[1][2] <= lb0[cur_col];
        win[2][2] <= pixel_in;
        s1_border <= (cur_row < RW'(2)) || (cur_col < CW'(2));
        s1_last   <= (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        s1_mode   <= cur_mode;
      end
    end
  end

  // Signed gradients over the current window
  always_comb begin
    gx_c = (ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]))
         - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
    gy_c = (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]))
         - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]));
  end

  // Stage 2: register gradients and the centre pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_border <= 1'b0;
      s2_last   <= 1'b0;
      s2_mode   <= '0;
      s2_centre <= '0;
      s2_gx     <= '0;
      s2_gy     <= '0;
    end else begin
      s2_valid  <= s1_valid;
      s2_border <= s1_border;
      s2_last   <= s1_last;
      s2_mode   <= s1_mode;
      s2_centre <= win[1][1];
      s2_gx     <= gx_c;
      s2_gy     <= gy_c;
    end
  end

  // Absolute values of the gradients
  always_comb begin
    ax_c = s2_gx[GW-1] ? $unsigned(-s2_gx) : $unsigned(s2_gx);
    ay_c = s2_gy[GW-1] ? $unsigned(-s2_gy) : $unsigned(s2_gy);
  end

  // Stage 3: register magnitudes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid  <= 1'b0;
      s3_border <= 1'b0;
      s3_last   <= 1'b0;
      s3_mode   <= '0;
      s3_centre <= '0;
      s3_ax     <= '0;
      s3_ay     <= '0;
    end else begin
      s3_valid  <= s2_valid;
      s3_border <= s2_border;
      s3_last   <= s2_last;
      s3_mode   <= s2_mode;
      s3_centre <= s2_centre;
      s3_ax     <= ax_c;
      s3_ay     <= ay_c;
    end
  end

  // Mode select, saturation and border mask (bypass is never masked)
  always_comb begin
    case (s3_mode)
      MODE_GX: mag_c = s3_ax;
      MODE_GY: mag_c = s3_ay;
      default: mag_c = s3_ax + s3_ay;
    endcase
    if (s3_mode == MODE_BYPASS) begin
      result_c = s3_centre;
    end else if (s3_border) begin
      result_c = '0;
    end else if (mag_c > SAT_MAX) begin
      result_c = SAT_MAX[PIX_W-1:0];
    end else begin
      result_c = mag_c[PIX_W-1:0];
    end
  end

  // Output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      pixel_out  <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= s3_valid;
      pixel_out  <= s3_valid ? result_c : '0;
      frame_done <= s3_valid & s3_last;
    end
  end

endmodule

// File: tb/tb_sobel_stream_param.sv
// Randomised bench for sobel_stream_param against a frame-image reference model.
module tb_sobel_stream_param;

  localparam int W = 8;
  localparam int H = 4;
  localparam int P = 8;
  localparam int PMAX = 255;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         frame_start;
  logic [1:0]   mode;
  logic [P-1:0] pixel_in;
  logic         out_valid;
  logic [P-1:0] pixel_out;
  logic         frame_done;

  always #5 clk = ~clk;

  sobel_stream_param #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .PIX_W     (P)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .frame_start(frame_start),
    .mode       (mode),
    .pixel_in   (pixel_in),
    .out_valid  (out_valid),
    .pixel_out  (pixel_out),
    .frame_done (frame_done)
  );

  typedef struct {
    int due;
    int val;
    bit chk;
    bit last;
  } rec_t;

  rec_t q[$];
  int   img[H][W];
  int   m_row, m_col, m_mode;
  int   cyc;
  int   tests, fails;
  int   log_v[$];
  int   log_fd[$];

  function automatic void check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  // Expected output for the pixel just accepted, from the frame image seen so far
  function automatic void model_accept(int pix, bit fs, int md_in);
    int   r, c, v, gx, gy, wt;
    rec_t rr;
    if (fs) begin
      m_row = 0;
      m_col = 0;
    end
    r = m_row;
    c = m_col;
    if (r == 0 && c == 0) m_mode = md_in;
    img[r][c] = pix;
    rr.chk = 1'b1;
    v = 0;
    if (m_mode == 3) begin
      rr.chk = (r >= 1 && c >= 1);
      if (rr.chk) v = img[r-1][c-1];
    end else if (r >= 2 && c >= 2) begin
      gx = 0;
      gy = 0;
      for (int i = 0; i < 3; i++) begin
        wt = (i == 1) ? 2 : 1;
        gx += wt * (img[r-2+i][c] - img[r-2+i][c-2]);
        gy += wt * (img[r][c-2+i] - img[r-2][c-2+i]);
      end
      case (m_mode)
        0:       v = iabs(gx);
        1:       v = iabs(gy);
        default: v = iabs(gx) + iabs(gy);
      endcase
      if (v > PMAX) v = PMAX;
    end
    rr.due  = cyc + 3;
    rr.val  = v;
    rr.last = (r == H - 1) && (c == W - 1);
    q.push_back(rr);
    if (c == W - 1) begin
      m_col = 0;
      m_row = (r == H - 1) ? 0 : r + 1;
    end else begin
      m_col = c + 1;
    end
  endfunction

  function automatic void compare();
    bit   ev;
    rec_t rr;
    while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
    ev = (q.size() > 0) && (q[0].due == cyc);
    check("out_valid", int'(out_valid), int'(ev));
    if (ev) begin
      rr = q.pop_front();
      if (rr.chk) check("pixel_out", int'(pixel_out), rr.val);
      check("frame_done", int'(frame_done), int'(rr.last));
    end else begin
      check("frame_done_idle", int'(frame_done), 0);
    end
    if (out_valid) begin
      log_v.push_back(int'(pixel_out));
      log_fd.push_back(int'(frame_done));
    end
  endfunction

  // One clock: drive inputs, model the accept at the edge, check outputs on the falling edge
  task automatic cycle(bit e, int pix, bit fs, int md);
    en          = e;
    pixel_in    = pix[P-1:0];
    frame_start = fs;
    mode        = md[1:0];
    @(posedge clk);
    cyc++;
    if (!rst && e) model_accept(pix, fs, md);
    @(negedge clk);
    compare();
  endtask

  function automatic int pix_of(int kind, int idx);
    int c;
    c = idx % W;
    case (kind)
      0:       return (c < 4) ? 0 : 10;
      1:       return (c < 4) ? 0 : 255;
      2:       return idx;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  // gap: 0 none, 1 one idle cycle after every pixel, 2 random idle runs
  task automatic send_frame(int kind, int md, int gap, int n, bit fsf);
    log_v.delete();
    log_fd.delete();
    for (int idx = 0; idx < n; idx++) begin
      cycle(1'b1, pix_of(kind, idx), (idx == 0) && fsf,
            (idx == 0) ? md : int'($urandom_range(0, 3)));
      if (gap == 1) cycle(1'b0, int'($urandom_range(0, 255)), 1'b0, 0);
      if (gap == 2) begin
        repeat ($urandom_range(0, 2))
          cycle(1'b0, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)));
      end
    end
  endtask

  task automatic drain();
    repeat (5) cycle(1'b0, 0, 1'b0, 0);
  endtask

  function automatic void lit(string name, int idx, int exp);
    if (idx < log_v.size()) check(name, log_v[idx], exp);
    else check(name, -1, exp);
  endfunction

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_pixel_out", int'(pixel_out), 0);
    check("rst_frame_done", int'(frame_done), 0);
    q.delete();
    m_row  = 0;
    m_col  = 0;
    m_mode = 0;
    en     = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    compare();
    #2 rst = 1'b0;
  endtask

  initial begin
    int sum;
    rst = 1'b1; en = 1'b0; frame_start = 1'b0; mode = '0; pixel_in = '0;
    cyc = 0; tests = 0; fails = 0; m_row = 0; m_col = 0; m_mode = 0;
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 0;
    #3;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_pixel_out", int'(pixel_out), 0);
    check("reset_frame_done", int'(frame_done), 0);
    @(negedge clk);
    #2 rst = 1'b0;

    // Vertical step 0/10, |Gx|
    send_frame(0, 0, 0, 32, 1'b1);
    drain();
    check("step_gx_count", log_v.size(), 32);
    lit("step_gx_r2c4", 20, 40);
    lit("step_gx_r2c5", 21, 40);
    lit("step_gx_r3c5", 29, 40);
    lit("step_gx_r2c6", 22, 0);
    lit("step_gx_r1c4", 12, 0);
    if (log_fd.size() == 32) check("step_gx_frame_done", log_fd[31], 1);
    else check("step_gx_frame_done_count", log_fd.size(), 32);

    // Same image, |Gy| all zero, then |Gx|+|Gy|
    send_frame(0, 1, 0, 32, 1'b1);
    drain();
    sum = 0;
    foreach (log_v[i]) sum += log_v[i];
    check("step_gy_sum", sum, 0);
    send_frame(0, 2, 0, 32, 1'b1);
    drain();
    lit("step_sum_r2c4", 20, 40);

    // 0/255 step saturates
    send_frame(1, 0, 0, 32, 1'b1);
    drain();
    lit("sat_r2c4", 20, 255);
    lit("sat_r3c4", 28, 255);

    // Same with alternating enable
    send_frame(1, 0, 1, 32, 1'b1);
    drain();
    check("gap_count", log_v.size(), 32);
    lit("gap_r2c5", 21, 255);
    lit("gap_r2c6", 22, 0);

    // Bypass on a ramp
    send_frame(2, 3, 0, 32, 1'b1);
    drain();
    lit("bypass_r2c2", 18, 9);
    lit("bypass_r3c7", 31, 22);

    // Reset mid-row 2, then restart
    send_frame(0, 2, 0, 20, 1'b1);
    do_reset();
    send_frame(0, 0, 0, 32, 1'b1);
    drain();
    lit("restart_r1c4", 12, 0);
    lit("restart_r2c4", 20, 40);

    // Random frames: random gaps, mid-frame restarts and wrap without frame_start
    for (int f = 0; f < 10; f++) begin
      send_frame(3, int'($urandom_range(0, 3)), 2,
                 (f % 4 == 3) ? int'($urandom_range(5, 30)) : 32, (f % 3 != 2));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sobel_stream_param.md
Name: sobel_stream_param

Overview:
- Parametrised, multi-mode successor to the SobelX stream filter.
- Accepts a raster pixel stream, one pixel per enabled clock.
- Keeps two line buffers and a 3x3 window, and produces |Gx|, |Gy|, |Gx|+|Gy| or a bypass pixel.
- Output stream is one-to-one with the input stream. It feeds the BMP write-back path unchanged.

Parameters:
- IMG_WIDTH, 640: pixels per row (>=3); line buffer depth.
- IMG_HEIGHT, 480: rows per frame (>=3); the row counter wraps here.
- PIX_W, 8: pixel width in bits; output saturates to 2^PIX_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  input valid; pixel_in is accepted on the rising edge when en=1.
- frame_start  in  1  qualified by en; the accepted pixel becomes row 0, col 0.
- mode  in  2  0=|Gx|, 1=|Gy|, 2=|Gx|+|Gy|, 3=bypass. Latched when a pixel at (0,0) is accepted.
- pixel_in  in  PIX_W  input pixel.
- out_valid  out  1  pixel_out is valid this cycle.
- pixel_out  out  PIX_W  filtered pixel.
- frame_done  out  1  one-cycle pulse, coincident with out_valid, for the output of the last pixel of a frame.

Behaviour:
- Reset (async, rst=1):
  - col, row and mode_q are cleared to 0.
  - out_valid=0, pixel_out=0, frame_done=0.
  - All pipeline valids are cleared.
  - Line buffer contents are don't-care, because border masking hides them.
- Position counters:
  - col increments on every accepted pixel. At IMG_WIDTH-1 it wraps to 0 and row increments.
  - row wraps to 0 after IMG_HEIGHT-1.
  - An accepted pixel with frame_start=1 forces position (0,0); the counters then advance from there. This also applies mid-frame.
- Window:
  - On accept, the 3x3 window shifts left by one column.
  - New right column, top to bottom: lb1[col], lb0[col], pixel_in.
  - Then lb1[col]<=lb0[col] and lb0[col]<=pixel_in.
  - Naming: p[i][j], i=0 is the oldest row, j=0 is the leftmost column.
- Gradients, computed on signed PIX_W+4 bits:
  - Gx = (p02+2p12+p22) - (p00+2p10+p20)
  - Gy = (p20+2p21+p22) - (p00+2p01+p02)
- Mapping and border mask:
  - The output for the input at (r,c) is the gradient centred at (r-1,c-1).
  - The output is forced to 0 when r<2 or c<2. This removes stale-row and cross-row data.
- Magnitude and output:
  - Compute |Gx|, |Gy| and their sum, select by mode_q, then saturate to 2^PIX_W-1.
  - Bypass outputs p11, the centre pixel, with no masking.
- Pipeline and latency:
  - Stage 1 (accept edge): counters and window update; border flag registered.
  - Stage 2: Gx and Gy registered.
  - Stage 3: abs, select, saturate, then pixel_out and out_valid.
  - out_valid is high exactly 3 clocks after the accepting edge, i.e. en sampled high at edge N gives out_valid=1 after edge N+3.
  - Throughput is 1 pixel/clk. The pipeline advances every clock regardless of en.
- Gaps: en=0 cycles insert bubbles only. The output values are identical to a gap-free run.
- No backpressure: the consumer must take pixel_out whenever out_valid=1.
- Mode: mode changes take effect only at the next accepted (0,0) pixel. Outputs already in flight keep their old mode.
- frame_done: asserted with the output belonging to input (IMG_HEIGHT-1, IMG_WIDTH-1).
- Reset mid-operation: in-flight outputs are discarded. No out_valid appears until 3 clocks after the next accept.

Test Plan (IMG_WIDTH=8, IMG_HEIGHT=4, PIX_W=8):
- Vertical step, cols 0-3=0 and cols 4-7=10, mode=0, en held high:
  - Outputs at input cols 4,5 with row>=2 are 40; all other outputs are 0.
  - 32 out_valid pulses; frame_done on the 32nd.
- Same image, mode=1: all 0. Mode=2: same as mode=0.
- Step of 0/255, mode=0: Gx=1020, so pixel_out saturates to 255 at cols 4,5 for rows>=2.
- Same image with en toggled 1,0,1,0 on alternate cycles: output values are identical in sequence to the gap-free run, with each out_valid 3 clocks after its accept.
- Assert rst asynchronously mid-row 2:
  - out_valid=0 immediately.
  - Restart with frame_start: the first 2 rows output 0, then the correct gradients follow.
  - mode written mid-frame is ignored until the next (0,0).
- mode=3 on ramp pixel_in=index 0..31: outputs equal the pixel at (r-1,c-1) with 3-cycle latency, e.g. input 18 at (2,2) yields 9.
